// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: clocked front-end around an asynchronous SPI master.
// Buffers TX/RX words, sequences wr/rd strobes and credits RX space.
module spi_burst_ctrl #(
    parameter int WORD_LEN   = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int HOLDOFF    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_LEN-1:0]   tx_data,
    input  logic                  tx_push,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   tx_level,
    output logic [WORD_LEN-1:0]   rx_data,
    input  logic                  rx_pop,
    output logic                  rx_empty,
    output logic [DEPTH_LOG2:0]   rx_level,
    output logic                  busy,
    output logic                  tx_ovf,
    input  logic                  clr_err,
    output logic [WORD_LEN-1:0]   m_data_in,
    output logic                  m_wr,
    input  logic                  m_buffempty,
    output logic                  m_rd,
    input  logic [WORD_LEN-1:0]   m_data_out,
    input  logic                  m_charreceived
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int AW    = DEPTH_LOG2;

    localparam logic [3:0]    HOLD_M1  = 4'(HOLDOFF - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_STROBE,
        TX_GAP
    } tx_st_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ASSERT,
        RX_CAPTURE,
        RX_RELEASE
    } rx_st_e;

    logic                bs_meta_q;
    logic                bs_q;
    logic                cs_meta_q;
    logic                cs_q;

    logic [WORD_LEN-1:0] tx_mem_q [DEPTH];
    logic [WORD_LEN-1:0] rx_mem_q [DEPTH];

    logic [LW-1:0]       tx_wptr_q;
    logic [LW-1:0]       tx_wptr_d;
    logic [LW-1:0]       tx_rptr_q;
    logic [LW-1:0]       tx_rptr_d;
    logic [LW-1:0]       rx_wptr_q;
    logic [LW-1:0]       rx_wptr_d;
    logic [LW-1:0]       rx_rptr_q;
    logic [LW-1:0]       rx_rptr_d;

    logic                tx_wr_en;
    logic                tx_rd_en;
    logic                rx_wr_en;
    logic                rx_rd_en;
    logic                tx_empty;
    logic                rx_full;

    logic                tx_ovf_q;
    logic                tx_ovf_d;

    logic [1:0]          out_q;
    logic [1:0]          out_d;
    logic                out_inc;
    logic                out_dec;
    logic [LW:0]         credit_sum;
    logic                tx_go;

    tx_st_e              tx_st_q;
    tx_st_e              tx_st_d;
    rx_st_e              rx_st_q;
    rx_st_e              rx_st_d;
    logic [3:0]          tx_cnt_q;
    logic [3:0]          tx_cnt_d;
    logic [3:0]          rx_cnt_q;
    logic [3:0]          rx_cnt_d;

    logic [WORD_LEN-1:0] m_data_in_q;
    logic [WORD_LEN-1:0] m_data_in_d;
    logic                m_wr_q;
    logic                m_wr_d;
    logic                m_rd_q;
    logic                m_rd_d;
    logic                rx_capture;

    // Occupancy flags derived from the extra-bit pointers.
    always_comb begin
        tx_level = tx_wptr_q - tx_rptr_q;
        rx_level = rx_wptr_q - rx_rptr_q;
        tx_full  = (tx_level == FULL_LVL);
        tx_empty = (tx_level == '0);
        rx_full  = (rx_level == FULL_LVL);
        rx_empty = (rx_level == '0);
        rx_data  = rx_empty ? '0 : rx_mem_q[rx_rptr_q[AW-1:0]];
    end

    // Issue only when the master can take a word and RX has a slot for
    // every word already handed to the master plus this one.
    always_comb begin
        credit_sum = {1'b0, rx_level} + {{(LW-1){1'b0}}, out_q};
        tx_go      = (tx_st_q == TX_IDLE) && !tx_empty && bs_q
                     && (out_q < 2'd2)
                     && (credit_sum < {1'b0, FULL_LVL});
    end

    // FIFO pointer, error flag and in-flight word bookkeeping.
    always_comb begin
        tx_wr_en  = tx_push && !tx_full;
        tx_rd_en  = tx_go;
        rx_wr_en  = rx_capture && !rx_full;
        rx_rd_en  = rx_pop && !rx_empty;
        tx_wptr_d = tx_wptr_q + LW'(tx_wr_en);
        tx_rptr_d = tx_rptr_q + LW'(tx_rd_en);
        rx_wptr_d = rx_wptr_q + LW'(rx_wr_en);
        rx_rptr_d = rx_rptr_q + LW'(rx_rd_en);

        tx_ovf_d = tx_ovf_q;
        if (clr_err) begin
            tx_ovf_d = 1'b0;
        end
        if (tx_push && tx_full) begin
            tx_ovf_d = 1'b1;
        end

        out_inc = (tx_st_q == TX_STROBE);
        out_dec = rx_capture;
        out_d   = out_q;
        if (out_inc && !out_dec) begin
            out_d = out_q + 2'd1;
        end else if (!out_inc && out_dec) begin
            out_d = out_q - 2'd1;
        end
    end

    // TX next-state: setup, one strobe cycle, then a holdoff gap.
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        unique case (tx_st_q)
            TX_IDLE: begin
                if (tx_go) begin
                    tx_st_d = TX_SETUP;
                end
            end
            TX_SETUP: begin
                tx_st_d = TX_STROBE;
            end
            TX_STROBE: begin
                tx_st_d  = TX_GAP;
                tx_cnt_d = HOLD_M1;
            end
            TX_GAP: begin
                if (tx_cnt_q == '0) begin
                    tx_st_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 4'd1;
                end
            end
            default: begin
                tx_st_d = TX_IDLE;
            end
        endcase
    end

    // RX next-state: hold rd two cycles, capture, release for holdoff.
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        unique case (rx_st_q)
            RX_IDLE: begin
                if (cs_q) begin
                    rx_st_d  = RX_ASSERT;
                    rx_cnt_d = 4'd1;
                end
            end
            RX_ASSERT: begin
                if (rx_cnt_q == '0) begin
                    rx_st_d = RX_CAPTURE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 4'd1;
                end
            end
            RX_CAPTURE: begin
                rx_st_d  = RX_RELEASE;
                rx_cnt_d = HOLD_M1;
            end
            RX_RELEASE: begin
                if (rx_cnt_q == '0) begin
                    rx_st_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 4'd1;
                end
            end
            default: begin
                rx_st_d = RX_IDLE;
            end
        endcase
    end

    // Strobe outputs are registered from next state so they never glitch.
    always_comb begin
        m_data_in_d = m_data_in_q;
        if (tx_go) begin
            m_data_in_d = tx_mem_q[tx_rptr_q[AW-1:0]];
        end
        m_wr_d     = (tx_st_d == TX_STROBE);
        m_rd_d     = (rx_st_d == RX_ASSERT) || (rx_st_d == RX_CAPTURE);
        rx_capture = (rx_st_q == RX_CAPTURE);
    end

    // Status outputs.
    always_comb begin
        m_data_in = m_data_in_q;
        m_wr      = m_wr_q;
        m_rd      = m_rd_q;
        tx_ovf    = tx_ovf_q;
        busy      = !tx_empty || (out_q != 2'd0)
                    || (tx_st_q != TX_IDLE) || (rx_st_q != RX_IDLE);
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (tx_wr_en) begin
            tx_mem_q[tx_wptr_q[AW-1:0]] <= tx_data;
        end
        if (rx_wr_en) begin
            rx_mem_q[rx_wptr_q[AW-1:0]] <= m_data_out;
        end
    end

    // State, pointers, synchronizers and registered master outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bs_meta_q   <= 1'b0;
            bs_q        <= 1'b0;
            cs_meta_q   <= 1'b0;
            cs_q        <= 1'b0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            tx_ovf_q    <= 1'b0;
            out_q       <= 2'd0;
            tx_st_q     <= TX_IDLE;
            rx_st_q     <= RX_IDLE;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            m_data_in_q <= '0;
            m_wr_q      <= 1'b0;
            m_rd_q      <= 1'b0;
        end else begin
            bs_meta_q   <= m_buffempty;
            bs_q        <= bs_meta_q;
            cs_meta_q   <= m_charreceived;
            cs_q        <= cs_meta_q;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            tx_ovf_q    <= tx_ovf_d;
            out_q       <= out_d;
            tx_st_q     <= tx_st_d;
            rx_st_q     <= rx_st_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            m_data_in_q <= m_data_in_d;
            m_wr_q      <= m_wr_d;
            m_rd_q      <= m_rd_d;
        end
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: bench for spi_burst_ctrl with a loopback master model.
// Vector table for TX overflow, directed corners, random batches.
module tb_spi_burst_ctrl;
    localparam int WL      = 8;
    localparam int DL      = 4;
    localparam int HOLDOFF = 4;
    localparam int XFER    = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [WL-1:0] tx_data = '0;
    logic          tx_push = 1'b0;
    logic          tx_full;
    logic [DL:0]   tx_level;
    logic [WL-1:0] rx_data;
    logic          rx_pop = 1'b0;
    logic          rx_empty;
    logic [DL:0]   rx_level;
    logic          busy;
    logic          tx_ovf;
    logic          clr_err = 1'b0;
    logic [WL-1:0] m_data_in;
    logic          m_wr;
    logic          m_buffempty;
    logic          m_rd;
    logic [WL-1:0] m_data_out = '0;
    logic          m_charreceived = 1'b0;

    always #5 clk = ~clk;

    spi_burst_ctrl #(
        .WORD_LEN  (WL),
        .DEPTH_LOG2(DL),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_push       (tx_push),
        .tx_full       (tx_full),
        .tx_level      (tx_level),
        .rx_data       (rx_data),
        .rx_pop        (rx_pop),
        .rx_empty      (rx_empty),
        .rx_level      (rx_level),
        .busy          (busy),
        .tx_ovf        (tx_ovf),
        .clr_err       (clr_err),
        .m_data_in     (m_data_in),
        .m_wr          (m_wr),
        .m_buffempty   (m_buffempty),
        .m_rd          (m_rd),
        .m_data_out    (m_data_out),
        .m_charreceived(m_charreceived)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int wr_count = 0;
    int lost_cnt = 0;
    int last_wr_cyc = -1000;
    logic [7:0] wr_exp[$];
    logic [7:0] rx_exp[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Loopback master: one holding buffer plus a shifter.
    logic       master_hold = 1'b0;
    logic       hv = 1'b0;
    logic       shifting = 1'b0;
    int         tmr = 0;
    logic [7:0] hold_w = '0;
    logic [7:0] shift_w = '0;
    logic       mwr_prev = 1'b0;
    logic       mrd_prev = 1'b0;

    assign m_buffempty = !hv && !master_hold;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            hv = 1'b0;
            shifting = 1'b0;
            tmr = 0;
            m_charreceived = 1'b0;
            m_data_out = '0;
            mwr_prev = 1'b0;
            mrd_prev = 1'b0;
        end else begin
            if (m_rd && !mrd_prev) m_charreceived = 1'b0;
            if (shifting) begin
                if (tmr == 0) begin
                    shifting = 1'b0;
                    if (m_charreceived) lost_cnt++;
                    m_data_out = shift_w;
                    m_charreceived = 1'b1;
                end else begin
                    tmr--;
                end
            end
            if (!shifting && hv) begin
                shift_w = hold_w;
                hv = 1'b0;
                shifting = 1'b1;
                tmr = XFER;
            end
            if (m_wr && !mwr_prev) begin
                if (hv) lost_cnt++;
                hold_w = m_data_in;
                hv = 1'b1;
            end
            mwr_prev = m_wr;
            mrd_prev = m_rd;
        end
    end

    // Strobe monitor: data order, setup before the edge, spacing.
    logic       mon_wr_prev = 1'b0;
    logic [7:0] mon_din_prev = '0;

    always @(negedge clk) begin
        if (rst && m_wr && !mon_wr_prev) begin
            wr_count++;
            chk("wr_setup", m_data_in, mon_din_prev);
            if (last_wr_cyc >= 0)
                chk("wr_spacing", (cyc - last_wr_cyc) >= 3 + HOLDOFF, 1);
            chk("wr_expected", wr_exp.size() > 0, 1);
            if (wr_exp.size() > 0) chk("wr_data", m_data_in, wr_exp.pop_front());
            last_wr_cyc = cyc;
        end
        mon_wr_prev = m_wr;
        mon_din_prev = m_data_in;
    end

    task automatic push_word(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_push = 1'b1;
        wr_exp.push_back(d);
        rx_exp.push_back(d);
        @(posedge clk);
        #1;
        tx_push = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, busy, 0);
    endtask

    task automatic pop_check(input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (rx_empty && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_avail"}, rx_empty, 0);
        chk({nm, "_model"}, rx_exp.size() > 0, 1);
        if (!rx_empty && rx_exp.size() > 0) begin
            chk(nm, rx_data, rx_exp.pop_front());
            rx_pop = 1'b1;
            @(posedge clk);
            #1;
            rx_pop = 1'b0;
        end
    endtask

    typedef struct packed {
        logic       push;
        logic       clr;
        logic [7:0] d;
        logic [4:0] lvl;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t vt[20];

    initial begin
        int base;
        int t;
        int n;

        for (int i = 0; i < 20; i++) begin
            vt[i].push = (i < 18);
            vt[i].clr  = (i == 17) || (i == 18);
            vt[i].d    = 8'(i * 7 + 3);
            vt[i].lvl  = (i < 16) ? 5'(i + 1) : 5'd16;
            vt[i].full = (i >= 15);
            vt[i].ovf  = (i == 16) || (i == 17);
        end

        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_push = ~tx_push;
            tx_data = 8'($urandom);
            @(posedge clk);
            #1;
            chk("rst_m_wr", m_wr, 0);
            chk("rst_m_rd", m_rd, 0);
            chk("rst_m_data_in", m_data_in, 0);
            chk("rst_tx_ovf", tx_ovf, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tx_full", tx_full, 0);
            chk("rst_rx_empty", rx_empty, 1);
            chk("rst_tx_level", tx_level, 0);
            chk("rst_rx_level", rx_level, 0);
            chk("rst_rx_data", rx_data, 0);
        end
        @(negedge clk);
        tx_push = 1'b0;
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_release_no_wr", wr_count, 0);
        chk("rst_release_level", tx_level, 0);

        base = wr_count;
        push_word(8'hA5);
        wait_idle("single_idle");
        chk("single_wr_cnt", wr_count - base, 1);
        chk("single_rx_level", rx_level, 1);
        pop_check("single_rx");
        chk("single_rx_empty", rx_empty, 1);

        base = wr_count;
        for (int i = 1; i <= 16; i++) push_word(8'(i));
        wait_idle("burst_idle");
        chk("burst_wr_cnt", wr_count - base, 16);
        chk("burst_rx_level", rx_level, 16);
        for (int i = 0; i < 16; i++) pop_check("burst_rx");
        chk("burst_rx_empty", rx_empty, 1);

        base = wr_count;
        for (int i = 0; i < 16; i++) push_word(8'(8'h40 + i));
        t = 0;
        while (rx_level != 16 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("bp_rx_fill", rx_level, 16);
        for (int i = 0; i < 4; i++) push_word(8'(8'h50 + i));
        repeat (300) @(negedge clk);
        chk("bp_rx_level", rx_level, 16);
        chk("bp_tx_level", tx_level, 4);
        chk("bp_busy", busy, 1);
        chk("bp_wr_cnt", wr_count - base, 16);
        chk("bp_master_clear", m_charreceived, 0);
        chk("bp_no_ovf", tx_ovf, 0);
        pop_check("bp_pop_one");
        repeat (300) @(negedge clk);
        chk("bp_wr_cnt_one_more", wr_count - base, 17);
        chk("bp_tx_level_after", tx_level, 3);
        chk("bp_rx_level_after", rx_level, 16);
        for (int i = 0; i < 19; i++) pop_check("bp_drain");
        wait_idle("bp_idle");
        chk("bp_wr_total", wr_count - base, 20);
        chk("bp_rx_empty", rx_empty, 1);

        master_hold = 1'b1;
        repeat (4) @(negedge clk);
        base = wr_count;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tx_push = vt[i].push;
            clr_err = vt[i].clr;
            tx_data = vt[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("ovf_level[%0d]", i), tx_level, vt[i].lvl);
            chk($sformatf("ovf_full[%0d]", i), tx_full, vt[i].full);
            chk($sformatf("ovf_flag[%0d]", i), tx_ovf, vt[i].ovf);
            chk($sformatf("ovf_busy[%0d]", i), busy, 1);
        end
        tx_push = 1'b0;
        clr_err = 1'b0;
        chk("ovf_no_wr", wr_count - base, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ovf_rst_level", tx_level, 0);
        chk("ovf_rst_full", tx_full, 0);
        chk("ovf_rst_flag", tx_ovf, 0);
        repeat (2) @(negedge clk);
        master_hold = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 4; i++) push_word(8'(8'h60 + i));
        t = 0;
        @(negedge clk);
        while (!m_wr && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("mb_strobe_seen", m_wr, 1);
        rst = 1'b0;
        #1;
        chk("mb_wr_drop", m_wr, 0);
        chk("mb_tx_level", tx_level, 0);
        chk("mb_rx_empty", rx_empty, 1);
        chk("mb_busy", busy, 0);
        wr_exp.delete();
        rx_exp.delete();
        last_wr_cyc = -1000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        base = wr_count;
        push_word(8'h3C);
        wait_idle("mb_idle");
        chk("mb_wr_cnt", wr_count - base, 1);
        pop_check("mb_rx");

        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 16);
            base = wr_count;
            for (int i = 0; i < n; i++) begin
                push_word(8'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                pop_check("rand_rx");
            end
            wait_idle("rand_idle");
            chk("rand_wr_cnt", wr_count - base, n);
            chk("rand_rx_empty", rx_empty, 1);
        end

        chk("master_no_lost", lost_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_burst_ctrl.md
Name: spi_burst_ctrl

Overview:
- Clocked front-end that sits directly upstream and downstream of the asynchronous SPI master.
- Buffers host words in a TX FIFO and feeds them to the master with clean setup/strobe timing on its edge-triggered wr.
- Collects every received word by strobing the master's rd and pushes it into an RX FIFO.
- Flow control guarantees no received word is ever lost.

Parameters:
- WORD_LEN, 8: SPI word width; must match the master.
- DEPTH_LOG2, 4: log2 of TX and RX FIFO depth (DEPTH = 16).
- HOLDOFF, 4: clk cycles to wait after each wr/rd strobe before sampling master status again; range 3..15.

Ports:
- clk  input  1  block clock
- rst  input  1  asynchronous active-low reset
- tx_data  input  WORD_LEN  word to transmit
- tx_push  input  1  push tx_data into the TX FIFO this cycle
- tx_full  output  1  TX FIFO full
- tx_level  output  DEPTH_LOG2+1  TX FIFO occupancy
- rx_data  output  WORD_LEN  head of RX FIFO (show-ahead)
- rx_pop  input  1  pop the RX head this cycle
- rx_empty  output  1  RX FIFO empty
- rx_level  output  DEPTH_LOG2+1  RX FIFO occupancy
- busy  output  1  a transfer is pending or in flight
- tx_ovf  output  1  sticky: a push was attempted while TX was full
- clr_err  input  1  clears tx_ovf
- m_data_in  output  WORD_LEN  to master data_in
- m_wr  output  1  to master wr (posedge-active)
- m_buffempty  input  1  from master buffempty
- m_rd  output  1  to master rd (posedge-active)
- m_data_out  input  WORD_LEN  from master data_out
- m_charreceived  input  1  from master charreceived

Behaviour:
- Reset (rst=0, asynchronous): both FIFOs empty; both FSMs in IDLE; outstanding=0.
  - Output values in reset: m_wr=0, m_rd=0, m_data_in=0, tx_ovf=0, busy=0, tx_full=0, rx_empty=1, levels=0, rx_data=0.
  - Reset mid-transfer aborts silently. The master has its own reset and must be reset alongside.
- Synchronizers: m_buffempty and m_charreceived each pass through a 2-flop synchronizer (bs, cs), because the master may run on another clock. m_data_out is sampled only while m_rd is held high.
- TX FIFO:
  - Push with tx_full=1 is dropped and sets tx_ovf the next cycle.
  - clr_err clears tx_ovf; if clr_err coincides with a rejected push, set wins.
- RX FIFO:
  - Pop with rx_empty=1 is ignored.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible by the issue rule below.
- outstanding: 2-bit count of words written to the master and not yet collected. Incremented at the TX STROBE cycle, decremented at the RX CAPTURE cycle; simultaneous inc and dec leave it unchanged.
- TX FSM:
  - IDLE -> SETUP when all of the following hold: TX not empty, bs=1, outstanding<2, and rx_level + outstanding < DEPTH.
  - SETUP (1 cycle): pop head into m_data_in, m_wr=0.
  - STROBE (1 cycle): m_wr=1, m_data_in held.
  - GAP: m_wr=0, m_data_in held, HOLDOFF cycles, then IDLE.
  - Back-to-back words: at least 3+HOLDOFF cycles apart.
- RX FSM:
  - IDLE -> ASSERT when cs=1.
  - ASSERT (2 cycles): m_rd=1.
  - CAPTURE (1 cycle): m_rd stays 1; m_data_out is pushed into the RX FIFO.
  - RELEASE: m_rd=0, HOLDOFF cycles so cs can clear, then IDLE.
- Concurrency: both FSMs run independently, so a TX strobe and an RX strobe may overlap.
- busy = TX not empty | outstanding≠0 | either FSM not IDLE.
- tx_level and rx_level update the cycle after a push or pop. rx_data is valid whenever rx_empty=0.

Test Plan:
- Reset check: hold rst=0 for 3 cycles while toggling tx_push -> all outputs at their reset values and tx_level=0; release rst -> no m_wr edge occurs.
- Single word, master loopback (mosi->miso, prescaller=0, mode 0): push 0xA5 -> exactly one m_wr pulse with m_data_in=0xA5; then rx_level=1, rx_data=0xA5, busy=0; rx_pop -> rx_empty=1.
- Burst: push 0x01..0x10 (16 words) -> 16 m_wr pulses in order; RX receives 0x01..0x10 in order; master ss stays low across the words when the TX FIFO is kept fed.
- RX backpressure: push 20 words, rx_pop never asserted -> rx_level stops at 16, outstanding=0, remaining words stay in TX FIFO (tx_level=4), master charreceived never lost; then pop one word -> exactly one more word is issued.
- TX overflow: with the master held idle (bs forced 0), push 17 words -> tx_full=1 after 16, tx_ovf=1 after the 17th; clr_err -> tx_ovf=0; tx_level stays 16.
- Reset mid-burst: assert rst during a STROBE cycle -> m_wr drops immediately (asynchronously), FIFOs empty, outstanding=0; a new push after release transfers normally.
